ros2_sub_msg_reader: RTL and testbench
======================================

ROS2_SUB_MSG_READER -- requirements
Module: ros2_sub_msg_reader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64: receive buffer depth in bytes, equal to ROS2_MAX_APP_DATA_LEN.
REQ-002 SHALL have parameter AW, default $clog2(MAX_LEN): buffer address width.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port sub_addr, input, AW: buffer write address from the ROS2 subscriber core.
REQ-006 SHALL have port sub_ce, input, 1: buffer chip enable.
REQ-007 SHALL have port sub_we, input, 1: buffer write enable.
REQ-008 SHALL have port sub_wdata, input, 8: buffer write data.
REQ-009 SHALL have port sub_len, input, 8: total application data length of the last received message.
REQ-010 SHALL have port sub_recv, input, 1: one-cycle pulse, new message complete in buffer.
REQ-011 SHALL have port sub_req, output, 1: buffer ownership request to the core.
REQ-012 SHALL have port sub_grant, input, 1: buffer ownership granted.
REQ-013 SHALL have port sub_rel, output, 1: one-cycle buffer release pulse.
REQ-014 SHALL have ports m_tdata (output, 8), m_tvalid (output, 1), m_tready (input, 1), m_tlast (output, 1): string byte stream.
REQ-015 SHALL have ports msg_cnt (output, 16), err_cnt (output, 8), ovr_cnt (output, 8), busy (output, 1).

Function
REQ-016 SHALL write mem[sub_addr] <= sub_wdata on every cycle with sub_ce & sub_we, in any state.
REQ-017 SHALL set a one-deep pending flag on sub_recv; a sub_recv while pending is already set SHALL increment ovr_cnt (saturating at 255) and is otherwise dropped.
REQ-018 SHALL implement the states IDLE, REQ, HDR, DATA and REL; busy SHALL be 1 in every state except IDLE.
REQ-019 IDLE: when pending=1, SHALL go to REQ and drive sub_req=1 in the next cycle.
REQ-020 REQ: SHALL hold sub_req=1 until sub_grant=1.
REQ-021 On grant, SHALL clear pending, latch sub_len into len_q, and go to HDR.
REQ-022 A sub_recv in the same cycle as the grant SHALL set pending again, not be lost.
REQ-023 HDR: SHALL read bytes 0..3 with 1-cycle read latency and form strlen as 32-bit little-endian (byte0 = LSB).
REQ-024 Error check: strlen==0, or strlen+4 > len_q, or strlen+4 > MAX_LEN SHALL increment err_cnt (saturating) and go to REL without any stream beat; the compare SHALL be done at 33-bit width (no wrap).
REQ-025 No error: SHALL go to DATA, streaming addresses 4 .. 4+strlen-2, i.e. strlen-1 bytes, excluding the CDR NUL terminator.
REQ-026 strlen==1: SHALL emit no beat and go directly to REL; this counts as a valid message.
REQ-027 DATA: each byte SHALL be read (1 cycle), then presented with m_tvalid=1.
REQ-028 m_tdata and m_tlast SHALL stay stable while m_tvalid & !m_tready.
REQ-029 Each transfer (m_tvalid & m_tready) SHALL advance to the next address; maximum rate is 1 byte per 2 cycles.
REQ-030 m_tlast SHALL be 1 only on the final byte.
REQ-031 After the final transfer, SHALL go to REL.
REQ-032 REL: SHALL drop sub_req, pulse sub_rel for exactly 1 cycle, increment msg_cnt on a non-error path (16-bit wrap to 0), and return to IDLE.
REQ-033 Deassertion of sub_grant outside REQ SHALL be ignored; the block owns the buffer until sub_rel.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE and clear pending, sub_req, sub_rel, m_tvalid, m_tlast, m_tdata, msg_cnt, err_cnt, ovr_cnt and busy to 0.
REQ-035 Buffer contents SHALL NOT be reset.
REQ-036 Reset asserted mid-DATA SHALL abort the stream with no sub_rel pulse.
REQ-037 Outputs SHALL take their reset values in the cycle after the reset edge.

Verification
REQ-038 Write LE header 22 plus "Message From FPGA - 3\0", sub_len=26, pulse recv, grant after 3 cycles, m_tready=1 -> 21 beats, "M".."3", tlast on '3', one sub_rel, msg_cnt=1.
REQ-039 Header strlen=40 with sub_len=26 -> err_cnt=1, zero beats, sub_rel pulses, msg_cnt unchanged.
REQ-040 m_tready toggled 0/1 every 3 cycles during stream -> byte order and values identical to REQ-038, data stable while stalled.
REQ-041 recv pulsed 3 times while busy -> ovr_cnt=2, exactly one further message processed after REL.
REQ-042 strlen=1 -> no beats, msg_cnt+1; rst_n=0 during beat 5 of REQ-038 -> all outputs 0 next cycle, no sub_rel.

Source files
------------

// File: rtl/ros2_sub_msg_reader.sv
// ---------------------------------------------------------------------------
// ros2_sub_msg_reader
//
// Purpose:
//   Owns a byte-wide receive buffer that the ROS2 subscriber core fills, and
//   turns each completed std_msgs/String payload into a byte stream. The
//   payload layout is a 32-bit little-endian CDR string length followed by
//   the characters and a NUL terminator; the NUL is not streamed.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   sub_addr/ce/we/wdata  - buffer write port driven by the subscriber core
//   sub_len               - application data length of the last message
//   sub_recv              - one-cycle "message complete" pulse
//   sub_req / sub_grant   - buffer ownership handshake
//   sub_rel               - one-cycle buffer release pulse
//   m_tdata/tvalid/tready/tlast - string byte stream
//   msg_cnt, err_cnt, ovr_cnt   - good messages, header errors, dropped recvs
//   busy                  - high whenever the reader is not idle
// ---------------------------------------------------------------------------
module ros2_sub_msg_reader #(
    parameter int MAX_LEN = 64,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] sub_addr,
    input  logic          sub_ce,
    input  logic          sub_we,
    input  logic [7:0]    sub_wdata,
    input  logic [7:0]    sub_len,
    input  logic          sub_recv,
    output logic          sub_req,
    input  logic          sub_grant,
    output logic          sub_rel,
    output logic [7:0]    m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic [15:0]   msg_cnt,
    output logic [7:0]    err_cnt,
    output logic [7:0]    ovr_cnt,
    output logic          busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;

    logic [7:0]    mem [0:MAX_LEN-1];

    logic [2:0]    state_q,    state_d;
    logic          pend_q,     pend_d;
    logic [7:0]    len_q,      len_d;
    logic [2:0]    hdr_q,      hdr_d;
    logic [31:0]   strlen_q,   strlen_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [AW-1:0] end_addr_q, end_addr_d;
    logic          phase_q,    phase_d;
    logic          err_q,      err_d;
    logic [7:0]    m_tdata_q,  m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q,  m_tlast_d;
    logic [15:0]   msg_cnt_q,  msg_cnt_d;
    logic [7:0]    err_cnt_q,  err_cnt_d;
    logic [7:0]    ovr_cnt_q,  ovr_cnt_d;

    logic          grant_take;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;
    logic [32:0]   need_len;
    logic          hdr_err;

    // Buffer write port is always live; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (sub_ce && sub_we) begin
            mem[sub_addr] <= sub_wdata;
        end
    end

    assign grant_take = (state_q == S_REQ) && sub_grant;
    assign rd_addr    = (state_q == S_HDR) ? AW'(hdr_q[1:0]) : addr_q;
    assign rd_byte    = mem[rd_addr];

    // Length checks are done at 33 bits so a huge strlen cannot wrap past them.
    assign need_len = {1'b0, strlen_q} + 33'd4;
    assign hdr_err  = (strlen_q == 32'd0)
                   || (need_len > {25'd0, len_q})
                   || (need_len > 33'(MAX_LEN));

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        len_d      = len_q;
        hdr_d      = hdr_q;
        strlen_d   = strlen_q;
        addr_d     = addr_q;
        end_addr_d = end_addr_q;
        phase_d    = phase_q;
        err_d      = err_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        msg_cnt_d  = msg_cnt_q;
        err_cnt_d  = err_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;

        // A recv coinciding with the grant re-arms pending instead of being
        // counted as an overrun, because the grant empties the slot.
        if (grant_take) begin
            pend_d = 1'b0;
        end
        if (sub_recv) begin
            if (pend_q && !grant_take) begin
                if (ovr_cnt_q != 8'hFF) begin
                    ovr_cnt_d = ovr_cnt_q + 8'd1;
                end
            end
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (sub_grant) begin
                    len_d   = sub_len;
                    hdr_d   = 3'd0;
                    err_d   = 1'b0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                // Steps 0..3 capture header bytes; step 4 judges the length.
                if (!hdr_q[2]) begin
                    case (hdr_q[1:0])
                        2'd0:    strlen_d[7:0]   = rd_byte;
                        2'd1:    strlen_d[15:8]  = rd_byte;
                        2'd2:    strlen_d[23:16] = rd_byte;
                        default: strlen_d[31:24] = rd_byte;
                    endcase
                    hdr_d = hdr_q + 3'd1;
                end else if (hdr_err) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = S_REL;
                end else if (strlen_q == 32'd1) begin
                    state_d = S_REL;
                end else begin
                    addr_d     = AW'(4);
                    end_addr_d = strlen_q[AW-1:0] + AW'(2);
                    phase_d    = 1'b0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                // Phase 0 reads the byte into the output register, phase 1
                // holds it until accepted.
                if (!phase_q) begin
                    m_tdata_d  = rd_byte;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (addr_q == end_addr_q);
                    phase_d    = 1'b1;
                end else if (m_tvalid_q && m_tready) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    phase_d    = 1'b0;
                    if (m_tlast_q) begin
                        state_d = S_REL;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_REL: begin
                if (!err_q) begin
                    msg_cnt_d = msg_cnt_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pend_q     <= 1'b0;
            len_q      <= 8'd0;
            hdr_q      <= 3'd0;
            strlen_q   <= 32'd0;
            addr_q     <= '0;
            end_addr_q <= '0;
            phase_q    <= 1'b0;
            err_q      <= 1'b0;
            m_tdata_q  <= 8'd0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            msg_cnt_q  <= 16'd0;
            err_cnt_q  <= 8'd0;
            ovr_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            len_q      <= len_d;
            hdr_q      <= hdr_d;
            strlen_q   <= strlen_d;
            addr_q     <= addr_d;
            end_addr_q <= end_addr_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            msg_cnt_q  <= msg_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    // The buffer stays claimed from request until the release cycle.
    assign sub_req  = (state_q == S_REQ) || (state_q == S_HDR) || (state_q == S_DATA);
    assign sub_rel  = (state_q == S_REL);
    assign busy     = (state_q != S_IDLE);
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign msg_cnt  = msg_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign ovr_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_ros2_sub_msg_reader.sv
// ---------------------------------------------------------------------------
// tb_ros2_sub_msg_reader
//
// Directed bench for ros2_sub_msg_reader: loads CDR string messages into the
// buffer, hands over ownership, and checks the streamed bytes, release
// pulses and counters against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ros2_sub_msg_reader;

    localparam int MAX_LEN = 64;
    localparam int AW      = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] sub_addr;
    logic          sub_ce;
    logic          sub_we;
    logic [7:0]    sub_wdata;
    logic [7:0]    sub_len;
    logic          sub_recv;
    logic          sub_req;
    logic          sub_grant;
    logic          sub_rel;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [15:0]   msg_cnt;
    logic [7:0]    err_cnt;
    logic [7:0]    ovr_cnt;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Owned by the monitor; the stimulus process only reads these.
    logic [7:0] beats[$];
    logic       lasts[$];
    int         rel_count    = 0;
    int         stall_checks = 0;
    int         stall_bad    = 0;
    logic       stall_prev   = 1'b0;
    logic [7:0] stall_data   = 8'd0;
    logic       stall_last   = 1'b0;

    string ref_msg = "Message From FPGA - 3";

    always #5 clk = ~clk;

    ros2_sub_msg_reader #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sub_addr  (sub_addr),
        .sub_ce    (sub_ce),
        .sub_we    (sub_we),
        .sub_wdata (sub_wdata),
        .sub_len   (sub_len),
        .sub_recv  (sub_recv),
        .sub_req   (sub_req),
        .sub_grant (sub_grant),
        .sub_rel   (sub_rel),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .msg_cnt   (msg_cnt),
        .err_cnt   (err_cnt),
        .ovr_cnt   (ovr_cnt),
        .busy      (busy)
    );

    // Inputs change 2ns after the rising edge, so on the falling edge both
    // sides are settled and a visible valid&ready is the transfer that the
    // next rising edge will take.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                stall_checks++;
                if (!m_tvalid || m_tdata !== stall_data || m_tlast !== stall_last) begin
                    stall_bad++;
                end
            end
            if (m_tvalid && m_tready) begin
                beats.push_back(m_tdata);
                lasts.push_back(m_tlast);
            end
            if (sub_rel) begin
                rel_count++;
            end
            stall_prev = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeByte(input int addr, input logic [7:0] data);
        sub_addr  = AW'(addr);
        sub_wdata = data;
        sub_ce    = 1'b1;
        sub_we    = 1'b1;
        tick();
        sub_ce    = 1'b0;
        sub_we    = 1'b0;
    endtask

    task automatic writeHeader(input logic [31:0] strlen);
        for (int i = 0; i < 4; i++) begin
            writeByte(i, strlen[8*i +: 8]);
        end
    endtask

    task automatic writeRefString();
        for (int i = 0; i < ref_msg.len(); i++) begin
            writeByte(4 + i, ref_msg[i]);
        end
        writeByte(4 + ref_msg.len(), 8'h00);
    endtask

    task automatic checkRefStream(input string tag, input int base);
        int n;
        int last_hits;
        n = beats.size() - base;
        checkOutput({tag, "_beats"}, n, 21);
        last_hits = 0;
        for (int i = 0; i < 21; i++) begin
            if (base + i < beats.size()) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), beats[base + i], ref_msg[i]);
                if (lasts[base + i]) last_hits++;
            end
        end
        if (base + 20 < lasts.size()) begin
            checkOutput({tag, "_tlast_on_3"}, lasts[base + 20], 1'b1);
        end
        checkOutput({tag, "_tlast_count"}, last_hits, 1);
    endtask

    // Full ownership cycle: optional recv pulse, wait for the request, grant
    // after a delay, then run until the release pulse is seen. Extra recv
    // pulses may be injected while the reader is busy.
    task automatic applyStimulus(input logic [7:0] len, input int grant_delay,
                                 input bit toggle_ready, input int extra_recv,
                                 input bit do_recv);
        int n;
        int rel0;
        if (do_recv) begin
            sub_len  = len;
            sub_recv = 1'b1;
            tick();
            sub_recv = 1'b0;
        end
        n = 0;
        while (!sub_req && n < 50) begin
            tick();
            n++;
        end
        checkOutput("req_seen", sub_req, 1'b1);
        repeat (grant_delay) tick();
        checkOutput("req_held", sub_req, 1'b1);
        checkOutput("busy_in_req", busy, 1'b1);
        sub_grant = 1'b1;
        tick();
        sub_grant = 1'b0;
        rel0 = rel_count;
        n = 0;
        while (rel_count == rel0 && n < 500) begin
            sub_recv = (extra_recv > 0) && (n >= 2) && (n < 2 + 2 * extra_recv) && (n % 2 == 0);
            m_tready = toggle_ready ? (((n / 3) % 2) == 1) : 1'b1;
            tick();
            n++;
        end
        sub_recv = 1'b0;
        m_tready = 1'b1;
        checkOutput("rel_seen", rel_count - rel0, 1);
        repeat (3) tick();
        checkOutput("rel_single", rel_count - rel0, 1);
    endtask

    initial begin
        int base;
        int rel0;
        int n;

        rst_n     = 1'b0;
        sub_addr  = '0;
        sub_ce    = 1'b0;
        sub_we    = 1'b0;
        sub_wdata = 8'd0;
        sub_len   = 8'd0;
        sub_recv  = 1'b0;
        sub_grant = 1'b0;
        m_tready  = 1'b1;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_sub_req",  sub_req,  1'b0);
        checkOutput("rst_sub_rel",  sub_rel,  1'b0);
        checkOutput("rst_tvalid",   m_tvalid, 1'b0);
        checkOutput("rst_tlast",    m_tlast,  1'b0);
        checkOutput("rst_tdata",    m_tdata,  8'd0);
        checkOutput("rst_msg_cnt",  msg_cnt,  16'd0);
        checkOutput("rst_err_cnt",  err_cnt,  8'd0);
        checkOutput("rst_ovr_cnt",  ovr_cnt,  8'd0);
        checkOutput("rst_busy",     busy,     1'b0);
        rst_n = 1'b1;
        tick();

        $display("[TB] nominal message, strlen 22");
        writeHeader(32'd22);
        writeRefString();
        base = beats.size();
        applyStimulus(8'd26, 3, 1'b0, 0, 1'b1);
        checkRefStream("nominal", base);
        checkOutput("nominal_msg_cnt", msg_cnt, 16'd1);
        checkOutput("nominal_err_cnt", err_cnt, 8'd0);
        checkOutput("nominal_idle",    busy,    1'b0);

        $display("[TB] strlen 40 exceeds sub_len 26");
        writeHeader(32'd40);
        base = beats.size();
        applyStimulus(8'd26, 3, 1'b0, 0, 1'b1);
        checkOutput("err_beats",   beats.size() - base, 0);
        checkOutput("err_err_cnt", err_cnt, 8'd1);
        checkOutput("err_msg_cnt", msg_cnt, 16'd1);

        $display("[TB] backpressure, ready toggling every 3 cycles");
        writeHeader(32'd22);
        base = beats.size();
        applyStimulus(8'd26, 3, 1'b1, 0, 1'b1);
        checkRefStream("stall", base);
        checkOutput("stall_seen",   stall_checks > 0, 1'b1);
        checkOutput("stall_stable", stall_bad, 0);
        checkOutput("stall_msg_cnt", msg_cnt, 16'd2);

        $display("[TB] three recv pulses while busy");
        base = beats.size();
        applyStimulus(8'd26, 3, 1'b0, 3, 1'b1);
        checkOutput("ovr_cnt_after", ovr_cnt, 8'd2);
        checkRefStream("ovr_first", base);
        base = beats.size();
        applyStimulus(8'd26, 2, 1'b0, 0, 1'b0);
        checkRefStream("ovr_second", base);
        checkOutput("ovr_msg_cnt", msg_cnt, 16'd4);
        repeat (5) tick();
        checkOutput("ovr_no_third_req", sub_req, 1'b0);
        checkOutput("ovr_no_third_busy", busy, 1'b0);

        $display("[TB] strlen 1, empty string");
        writeHeader(32'd1);
        base = beats.size();
        applyStimulus(8'd26, 3, 1'b0, 0, 1'b1);
        checkOutput("one_beats",   beats.size() - base, 0);
        checkOutput("one_msg_cnt", msg_cnt, 16'd5);
        checkOutput("one_err_cnt", err_cnt, 8'd1);

        $display("[TB] reset during beat 5");
        writeHeader(32'd22);
        base = beats.size();
        sub_len  = 8'd26;
        sub_recv = 1'b1;
        tick();
        sub_recv = 1'b0;
        n = 0;
        while (!sub_req && n < 50) begin
            tick();
            n++;
        end
        checkOutput("mid_req_seen", sub_req, 1'b1);
        repeat (3) tick();
        sub_grant = 1'b1;
        tick();
        sub_grant = 1'b0;
        n = 0;
        while (!(m_tvalid && (beats.size() - base) == 4) && n < 200) begin
            tick();
            n++;
        end
        checkOutput("mid_beat5_valid", m_tvalid, 1'b1);
        checkOutput("mid_beat5_data",  m_tdata,  ref_msg[4]);
        rel0  = rel_count;
        rst_n = 1'b0;
        tick();
        checkOutput("mid_sub_req",  sub_req,  1'b0);
        checkOutput("mid_sub_rel",  sub_rel,  1'b0);
        checkOutput("mid_tvalid",   m_tvalid, 1'b0);
        checkOutput("mid_tlast",    m_tlast,  1'b0);
        checkOutput("mid_tdata",    m_tdata,  8'd0);
        checkOutput("mid_msg_cnt",  msg_cnt,  16'd0);
        checkOutput("mid_err_cnt",  err_cnt,  8'd0);
        checkOutput("mid_ovr_cnt",  ovr_cnt,  8'd0);
        checkOutput("mid_busy",     busy,     1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checkOutput("mid_no_rel", rel_count - rel0, 0);
        checkOutput("mid_stays_idle", busy, 1'b0);

        $display("[TB] buffer contents survive reset");
        base = beats.size();
        applyStimulus(8'd26, 3, 1'b0, 0, 1'b1);
        checkRefStream("retain", base);
        checkOutput("retain_msg_cnt", msg_cnt, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
